// File: rtl/video_timing.sv
// rtl/video_timing.sv - raster counters with delay-matched hsync/vsync/de/rgb for a DVI encoder
// Optional colour-bar generator enabled by VIDEO_TIMING_PATTERN_EN.
module video_timing #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int PIPE_DELAY = 2
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic [23:0] rgb_in,
`ifdef VIDEO_TIMING_PATTERN_EN
    input  logic        pattern,
`endif
    output logic [10:0] cx,
    output logic [10:0] cy,
    output logic        line_start,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [23:0] rgb
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [10:0] cx_q, cx_d;
    logic [10:0] cy_q, cy_d;
    logic        hs0, vs0, de0;
    logic        de_tap;
    logic [23:0] pix;
    logic [23:0] rgb_q;

    // Each stage holds {hs, vs, de} as active-high flags; polarity is applied at the pins.
    logic [2:0]  pipe_q [0:PIPE_DELAY];

    always_comb begin
        cx_d = cx_q + 11'd1;
        cy_d = cy_q;
        if (cx_q == 11'(H_TOTAL - 1)) begin
            cx_d = '0;
            cy_d = (cy_q == 11'(V_TOTAL - 1)) ? 11'd0 : cy_q + 11'd1;
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            cx_q <= '0;
            cy_q <= '0;
        end else begin
            cx_q <= cx_d;
            cy_q <= cy_d;
        end
    end

    assign de0 = (cx_q < 11'(H_ACTIVE)) && (cy_q < 11'(V_ACTIVE));
    assign hs0 = (cx_q >= 11'(H_ACTIVE + H_FP)) && (cx_q < 11'(H_ACTIVE + H_FP + H_SYNC));
    assign vs0 = (cy_q >= 11'(V_ACTIVE + V_FP)) && (cy_q < 11'(V_ACTIVE + V_FP + V_SYNC));

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            for (int i = 0; i <= PIPE_DELAY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= {hs0, vs0, de0};
            for (int i = 1; i <= PIPE_DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // de as seen by the cycle in which rgb_in for the same coordinate arrives.
    generate
        if (PIPE_DELAY == 0) begin : g_tap_raw
            assign de_tap = de0;
        end else begin : g_tap_pipe
            assign de_tap = pipe_q[PIPE_DELAY-1][0];
        end
    endgenerate

`ifdef VIDEO_TIMING_PATTERN_EN
    logic [10:0] cx_tap;
    logic [10:0] bar_idx;
    logic [23:0] bar_rgb;

    generate
        if (PIPE_DELAY == 0) begin : g_cx_raw
            assign cx_tap = cx_q;
        end else begin : g_cx_pipe
            logic [10:0] cxd_q [0:PIPE_DELAY-1];
            always_ff @(posedge clk_pixel) begin
                if (reset) begin
                    for (int i = 0; i < PIPE_DELAY; i++) begin
                        cxd_q[i] <= '0;
                    end
                end else begin
                    cxd_q[0] <= cx_q;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        cxd_q[i] <= cxd_q[i-1];
                    end
                end
            end
            assign cx_tap = cxd_q[PIPE_DELAY-1];
        end
    endgenerate

    // Bar width is H_ACTIVE/8, so H_ACTIVE must be at least 8.
    assign bar_idx = cx_tap / 11'(H_ACTIVE / 8);

    always_comb begin
        bar_rgb = 24'h000000;
        case (bar_idx)
            11'd0:   bar_rgb = 24'hFFFFFF;
            11'd1:   bar_rgb = 24'hFFFF00;
            11'd2:   bar_rgb = 24'h00FFFF;
            11'd3:   bar_rgb = 24'h00FF00;
            11'd4:   bar_rgb = 24'hFF00FF;
            11'd5:   bar_rgb = 24'hFF0000;
            11'd6:   bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    always_comb begin
        pix = rgb_in;
        if (pattern) begin
            pix = bar_rgb;
        end
    end
`else
    always_comb begin
        pix = rgb_in;
    end
`endif

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= de_tap ? pix : 24'h0;
        end
    end

    // Gated by reset so the pulses never appear while the counters are held.
    assign line_start  = !reset && (cx_q == 11'd0);
    assign frame_start = line_start && (cy_q == 11'd0);

    assign cx    = cx_q;
    assign cy    = cy_q;
    assign hsync = pipe_q[PIPE_DELAY][2] ? HSYNC_POL : !HSYNC_POL;
    assign vsync = pipe_q[PIPE_DELAY][1] ? VSYNC_POL : !VSYNC_POL;
    assign de    = pipe_q[PIPE_DELAY][0];
    assign rgb   = rgb_q;

endmodule

// File: tb/tb_video_timing.sv
// tb/tb_video_timing.sv - randomized raster check of video_timing against an arithmetic timing model
module tb_video_timing;

    localparam int HA = 16, HF = 4, HS = 6, HB = 5;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int PD_A = 2;
    localparam int PD_B = 0;
    localparam int N_CYC = 2600;

    localparam logic [23:0] BARS [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] rgb_in = '0;
`ifdef VIDEO_TIMING_PATTERN_EN
    logic        pattern = 1'b0;
    logic        pat_hist [0:15];
`endif

    logic [10:0] cx_a, cy_a, cx_b, cy_b;
    logic        ls_a, fs_a, hs_a, vs_a, de_a;
    logic        ls_b, fs_b, hs_b, vs_b, de_b;
    logic [23:0] rgb_a, rgb_b;

    logic [23:0] rgb_hist [0:15];
    int          t;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DELAY(PD_A)
    ) u_dut_a (
        .clk_pixel(clk), .reset(reset), .rgb_in(rgb_in),
`ifdef VIDEO_TIMING_PATTERN_EN
        .pattern(pattern),
`endif
        .cx(cx_a), .cy(cy_a), .line_start(ls_a), .frame_start(fs_a),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .rgb(rgb_a)
    );

    video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DELAY(PD_B)
    ) u_dut_b (
        .clk_pixel(clk), .reset(reset), .rgb_in(rgb_in),
`ifdef VIDEO_TIMING_PATTERN_EN
        .pattern(pattern),
`endif
        .cx(cx_b), .cy(cy_b), .line_start(ls_b), .frame_start(fs_b),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .rgb(rgb_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d: got %0h, expected %0h", tag, t, obs, exp);
        end
    endtask

    // {hs, vs, de} active-high for the coordinate presented u cycles after reset release.
    function automatic logic [2:0] raw_at(input int u);
        int x, y;
        x = u % HT;
        y = (u / HT) % VT;
        return {(x >= HA + HF) && (x < HA + HF + HS),
                (y >= VA + VF) && (y < VA + VF + VS),
                (x < HA) && (y < VA)};
    endfunction

    // Pixel the source delivered in cycle k for the coordinate of cycle u.
    function automatic logic [23:0] exp_pix(input int k, input int u);
`ifdef VIDEO_TIMING_PATTERN_EN
        if (pat_hist[k % 16]) begin
            return BARS[(u % HT) / (HA / 8)];
        end
`endif
        return rgb_hist[k % 16];
    endfunction

    task automatic check_dut(input string name, input int pd, input bit hpol, input bit vpol,
                             input logic hs, input logic vs, input logic d, input logic [23:0] px);
        logic [2:0]  r;
        logic [23:0] er;
        r  = (t >= pd + 1) ? raw_at(t - pd - 1) : 3'b000;
        er = r[0] ? exp_pix(t - 1, t - pd - 1) : 24'h0;
        check({name, ".hsync"}, 32'(hs), 32'(r[2] ? hpol : !hpol));
        check({name, ".vsync"}, 32'(vs), 32'(r[1] ? vpol : !vpol));
        check({name, ".de"},    32'(d),  32'(r[0]));
        check({name, ".rgb"},   32'(px), 32'(er));
    endtask

    task automatic check_inactive(input string name, input bit hpol, input bit vpol,
                                  input logic hs, input logic vs, input logic d, input logic [23:0] px);
        check({name, ".hsync_rst"}, 32'(hs), 32'(!hpol));
        check({name, ".vsync_rst"}, 32'(vs), 32'(!vpol));
        check({name, ".de_rst"},    32'(d),  32'd0);
        check({name, ".rgb_rst"},   32'(px), 32'd0);
    endtask

    initial begin
        int  r2, l2, fs_last, de_cnt, hs_run;
        bit  rst_prev;
        r2 = 1700 + int'($urandom_range(0, 60));
        l2 = int'($urandom_range(1, 4));
        t = -1;
        rst_prev = 1'b0;
        fs_last = -1;
        de_cnt = 0;
        hs_run = 0;
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            #1;
            reset = (cyc < 5) || (cyc >= 1000 && cyc < 1003) || (cyc >= r2 && cyc < r2 + l2);
            rgb_in = 24'($urandom);
            if (reset) t = -1;
            else       t++;
            if (!reset) rgb_hist[t % 16] = rgb_in;
`ifdef VIDEO_TIMING_PATTERN_EN
            pattern = ((cyc / 400) % 2 == 1) ? 1'b1 : 1'(($urandom_range(0, 7) == 0));
            if (!reset) pat_hist[t % 16] = pattern;
`endif
            @(negedge clk);
            if (reset) begin
                check("a.line_start_rst",  32'(ls_a), 32'd0);
                check("a.frame_start_rst", 32'(fs_a), 32'd0);
                check("b.line_start_rst",  32'(ls_b), 32'd0);
                if (rst_prev) begin
                    check("a.cx_rst", 32'(cx_a), 32'd0);
                    check("a.cy_rst", 32'(cy_a), 32'd0);
                    check_inactive("a", 1'b0, 1'b0, hs_a, vs_a, de_a, rgb_a);
                    check_inactive("b", 1'b1, 1'b1, hs_b, vs_b, de_b, rgb_b);
                end
                fs_last = -1;
                de_cnt = 0;
                hs_run = 0;
            end else begin
                check("a.cx", 32'(cx_a), 32'(t % HT));
                check("a.cy", 32'(cy_a), 32'((t / HT) % VT));
                check("b.cx", 32'(cx_b), 32'(t % HT));
                check("b.cy", 32'(cy_b), 32'((t / HT) % VT));
                check("a.line_start",  32'(ls_a), 32'(t % HT == 0));
                check("a.frame_start", 32'(fs_a), 32'(t % FRAME == 0));
                check("b.frame_start", 32'(fs_b), 32'(t % FRAME == 0));
                check_dut("a", PD_A, 1'b0, 1'b0, hs_a, vs_a, de_a, rgb_a);
                check_dut("b", PD_B, 1'b1, 1'b1, hs_b, vs_b, de_b, rgb_b);
                if (fs_a) begin
                    if (fs_last >= 0) begin
                        check("a.frame_period", 32'(t - fs_last), 32'(FRAME));
                        check("a.de_per_frame", 32'(de_cnt), 32'(HA * VA));
                    end
                    fs_last = t;
                    de_cnt = 0;
                end
                if (de_a) de_cnt++;
                if (!hs_a) begin
                    hs_run++;
                end else if (hs_run > 0) begin
                    check("a.hsync_width", 32'(hs_run), 32'(HS));
                    hs_run = 0;
                end
            end
            rst_prev = reset;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing.md
# video_timing

Pixel-clock raster generator that sits directly upstream of the DVI encoder. It runs horizontal and vertical counters and exports the current pixel coordinate to the pixel source. It then delays hsync, vsync and de by a configurable pipeline depth so they line up with the returned pixel data. Its rgb/hsync/vsync/de outputs connect directly to the DVI encoder inputs.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active low)
- VSYNC_POL, 0, active level of vsync
- PIPE_DELAY, 2, cycles from cx/cy to valid rgb_in; range 0..15
- clk_pixel  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- rgb_in  in  24  pixel from source, {R,G,B}, valid PIPE_DELAY cycles after its cx/cy
- cx  out  11  current horizontal count
- cy  out  11  current vertical count
- line_start  out  1  pulse when cx==0
- frame_start  out  1  pulse when cx==0 and cy==0
- hsync  out  1  aligned horizontal sync
- vsync  out  1  aligned vertical sync
- de  out  1  aligned data enable
- rgb  out  24  aligned pixel, forced to 0 when de=0
- pattern  in  1  test-pattern select (only with VIDEO_TIMING_PATTERN_EN)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤ 2048.
- cx increments every cycle.
  - At cx==H_TOTAL-1, cx wraps to 0 and cy increments.
  - At cy==V_TOTAL-1 together with cx wrap, cy wraps to 0.
- Raw (stage-0) signals are decoded combinationally from cx/cy:
  - de0 = (cx<H_ACTIVE)&&(cy<V_ACTIVE).
  - hs0 is active when H_ACTIVE+H_FP ≤ cx < H_ACTIVE+H_FP+H_SYNC.
  - vs0 is active when V_ACTIVE+V_FP ≤ cy < V_ACTIVE+V_FP+V_SYNC, over whole lines, with the transition at cx==0.
- hs0/vs0/de0 enter a shift register PIPE_DELAY+1 deep. The final stage drives hsync/vsync/de. Polarity is applied as level = active ? POL : !POL.
- rgb is registered from rgb_in when the PIPE_DELAY-stage de tap is 1, else from 24'h0. rgb is therefore aligned with de.
- No backpressure: the source must deliver rgb_in exactly PIPE_DELAY cycles after the coordinate is presented.

## Timing
- Reset values:
  - cx=0, cy=0; all delay stages hold inactive.
  - hsync=!HSYNC_POL, vsync=!VSYNC_POL, de=0, rgb=0, line_start=0, frame_start=0.
- First cycle after reset deasserts: cx=0, cy=0, line_start=1, frame_start=1.
- Latency: a coordinate presented at cycle n produces its hsync/vsync/de/rgb at cycle n+PIPE_DELAY+1.
- Reset mid-frame: counters return to 0 on the next edge. Outputs stay inactive until the first post-reset coordinate emerges (PIPE_DELAY+1 cycles). No partial sync pulse is emitted after reset.
- PIPE_DELAY=0: rgb_in is sampled in the same cycle as cx/cy, and outputs follow one cycle later.
- Simultaneous wraps (cx and cy at their maximum): both counters go to 0 in one cycle, and frame_start pulses in that next cycle.

## Configuration
- Macro: VIDEO_TIMING_PATTERN_EN.
- Defined:
  - The pattern port exists.
  - When pattern=1, the rgb_in sample is replaced by eight vertical colour bars chosen by the delayed cx / (H_ACTIVE/8). The bar order is white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Timing is unchanged.
- Undefined: the pattern port and bar logic are absent, and rgb always comes from rgb_in.

## Test plan
- Reset held 5 cycles, then released → hsync=1, vsync=1, de=0, rgb=0 during reset. The first cycle after release has cx=0, cy=0, frame_start=1.
- Default params, free-run 2 frames → frame_start pulses exactly 420000 cycles apart. de is high for 307200 cycles per frame, 640 contiguous per active line.
- Line 0 timing → hsync low for exactly 96 cycles, beginning 659 cycles after line_start (656+PIPE_DELAY+1).
- Vsync → low for exactly 2×800 cycles, starting when cy becomes 490. Its edges coincide with hsync-aligned line boundaries at the output.
- rgb_in driven as {cy[7:0],cx[7:0],8'hA5}, PIPE_DELAY=2 → at every de=1 output cycle, rgb matches the coordinate from 3 cycles earlier. rgb=0 whenever de=0.
- With VIDEO_TIMING_PATTERN_EN, pattern=1 → output pixels 0–79 are FFFFFF, 80–159 are FFFF00, and 560–639 are 000000.
- Reset asserted at cx=300, cy=200 → outputs go inactive, and the next frame_start occurs one cycle after release.
